// File: rtl/cpumc_pkg.sv
// Shared encodings and widths for the CPU memory-bus arbiter.
package cpumc_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   localparam logic [1:0] OWNER_CPU  = 2'd0;
   localparam logic [1:0] OWNER_HCI  = 2'd1;
   localparam logic [1:0] OWNER_DMA  = 2'd2;
   localparam logic [1:0] OWNER_NONE = 2'd3;

   typedef enum logic [2:0] {
      ST_CPU,
      ST_STALL,
      ST_HCI,
      ST_DMA,
      ST_GUARD
   } state_t;

endpackage

// File: rtl/cpumc_arbiter_if.sv
// CPU memory-bus signal bundle: three requester ports, the shared bus and arbiter status.
interface cpumc_arbiter_if;
   import cpumc_pkg::*;

   logic [ADDR_W-1:0] cpu_a_in;
   logic              cpu_r_nw_in;
   logic [DATA_W-1:0] cpu_d_in;
   logic              cpu_rdy_out;

   logic              hci_req_in;
   logic              hci_gnt_out;
   logic [ADDR_W-1:0] hci_a_in;
   logic              hci_r_nw_in;
   logic [DATA_W-1:0] hci_d_in;

   logic              dma_req_in;
   logic              dma_gnt_out;
   logic [ADDR_W-1:0] dma_a_in;
   logic              dma_r_nw_in;
   logic [DATA_W-1:0] dma_d_in;

   logic [ADDR_W-1:0] mc_a_out;
   logic              mc_r_nw_out;
   logic [DATA_W-1:0] mc_d_out;
   logic [1:0]        owner_out;
   logic              protocol_err_out;

   modport slave (
      input  cpu_a_in, cpu_r_nw_in, cpu_d_in,
      input  hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
      input  dma_req_in, dma_a_in, dma_r_nw_in, dma_d_in,
      output cpu_rdy_out, hci_gnt_out, dma_gnt_out,
      output mc_a_out, mc_r_nw_out, mc_d_out, owner_out, protocol_err_out
   );

   modport master (
      output cpu_a_in, cpu_r_nw_in, cpu_d_in,
      output hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
      output dma_req_in, dma_a_in, dma_r_nw_in, dma_d_in,
      input  cpu_rdy_out, hci_gnt_out, dma_gnt_out,
      input  mc_a_out, mc_r_nw_out, mc_d_out, owner_out, protocol_err_out
   );

endinterface

// File: rtl/cpumc_arbiter.sv
// Shares the CPU memory bus between the rp2a03, HCI and DMA. The CPU is stalled via RDY
// and the bus only changes hands on a CPU read cycle, since RDY cannot halt a 6502 write.
module cpumc_arbiter
   import cpumc_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES = 1,
   parameter int unsigned MAX_WR_WAIT  = 3
) (
   input  logic           clk_in,
   input  logic           rst_in,
   cpumc_arbiter_if.slave bus
);

   localparam logic [7:0] WR_LIMIT   = 8'(MAX_WR_WAIT);
   localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

   state_t     state, state_nxt;
   logic       rdy, rdy_nxt;
   logic       hci_gnt, hci_gnt_nxt;
   logic       dma_gnt, dma_gnt_nxt;
   logic [1:0] owner, owner_nxt;
   logic       err, err_nxt;
   logic [3:0] guard_cnt, guard_nxt;
   logic [7:0] wr_wait, wr_wait_nxt;

   logic       any_req;
   state_t     resume_state, rel_state;
   logic       resume_rdy, rel_rdy;
   logic [1:0] resume_owner, rel_owner;

   assign any_req = bus.hci_req_in | bus.dma_req_in;

   // Where to go once nobody owns the bus: back to STALL if someone is waiting, else CPU.
   // A release enters GUARD first unless the guard window is configured away.
   always_comb begin
      resume_state = ST_CPU;
      resume_rdy   = 1'b1;
      resume_owner = OWNER_CPU;
      if (any_req) begin
         resume_state = ST_STALL;
         resume_rdy   = 1'b0;
         resume_owner = OWNER_NONE;
      end
      rel_state = ST_GUARD;
      rel_rdy   = 1'b0;
      rel_owner = OWNER_NONE;
      if (GUARD_CYCLES == 0) begin
         rel_state = resume_state;
         rel_rdy   = resume_rdy;
         rel_owner = resume_owner;
      end
   end

   always_comb begin
      state_nxt   = state;
      rdy_nxt     = 1'b0;
      owner_nxt   = OWNER_NONE;
      hci_gnt_nxt = 1'b0;
      dma_gnt_nxt = 1'b0;
      guard_nxt   = '0;
      wr_wait_nxt = '0;
      err_nxt     = err;
      unique case (state)
         ST_CPU: begin
            if (any_req) begin
               state_nxt = ST_STALL;
            end else begin
               rdy_nxt   = 1'b1;
               owner_nxt = OWNER_CPU;
            end
         end
         ST_STALL: begin
            if (!any_req) begin
               state_nxt = resume_state;
               rdy_nxt   = resume_rdy;
               owner_nxt = resume_owner;
            end else if (bus.cpu_r_nw_in) begin
               if (bus.hci_req_in) begin
                  state_nxt   = ST_HCI;
                  hci_gnt_nxt = 1'b1;
                  owner_nxt   = OWNER_HCI;
               end else begin
                  state_nxt   = ST_DMA;
                  dma_gnt_nxt = 1'b1;
                  owner_nxt   = OWNER_DMA;
               end
            end else begin
               // CPU still writing: keep waiting, flag a CPU that never reaches a read.
               wr_wait_nxt = (wr_wait == '1) ? wr_wait : wr_wait + 8'd1;
               if (wr_wait >= WR_LIMIT) err_nxt = 1'b1;
            end
         end
         ST_HCI: begin
            if (bus.hci_req_in) begin
               hci_gnt_nxt = 1'b1;
               owner_nxt   = OWNER_HCI;
            end else begin
               state_nxt = rel_state;
               rdy_nxt   = rel_rdy;
               owner_nxt = rel_owner;
            end
         end
         ST_DMA: begin
            if (bus.dma_req_in) begin
               dma_gnt_nxt = 1'b1;
               owner_nxt   = OWNER_DMA;
            end else begin
               state_nxt = rel_state;
               rdy_nxt   = rel_rdy;
               owner_nxt = rel_owner;
            end
         end
         ST_GUARD: begin
            if (guard_cnt == GUARD_LAST) begin
               state_nxt = resume_state;
               rdy_nxt   = resume_rdy;
               owner_nxt = resume_owner;
            end else begin
               guard_nxt = guard_cnt + 4'd1;
            end
         end
         default: begin
            state_nxt = ST_CPU;
            rdy_nxt   = 1'b1;
            owner_nxt = OWNER_CPU;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= ST_CPU;
         rdy       <= 1'b1;
         hci_gnt   <= 1'b0;
         dma_gnt   <= 1'b0;
         owner     <= OWNER_CPU;
         err       <= 1'b0;
         guard_cnt <= '0;
         wr_wait   <= '0;
      end else begin
         state     <= state_nxt;
         rdy       <= rdy_nxt;
         hci_gnt   <= hci_gnt_nxt;
         dma_gnt   <= dma_gnt_nxt;
         owner     <= owner_nxt;
         err       <= err_nxt;
         guard_cnt <= guard_nxt;
         wr_wait   <= wr_wait_nxt;
      end
   end

   // While nobody owns the bus the CPU address is presented but writes are suppressed.
   always_comb begin
      bus.mc_a_out    = bus.cpu_a_in;
      bus.mc_r_nw_out = 1'b1;
      bus.mc_d_out    = bus.cpu_d_in;
      unique case (state)
         ST_CPU: bus.mc_r_nw_out = bus.cpu_r_nw_in;
         ST_HCI: begin
            bus.mc_a_out    = bus.hci_a_in;
            bus.mc_r_nw_out = bus.hci_r_nw_in;
            bus.mc_d_out    = bus.hci_d_in;
         end
         ST_DMA: begin
            bus.mc_a_out    = bus.dma_a_in;
            bus.mc_r_nw_out = bus.dma_r_nw_in;
            bus.mc_d_out    = bus.dma_d_in;
         end
         default: ;
      endcase
   end

   assign bus.cpu_rdy_out      = rdy;
   assign bus.hci_gnt_out      = hci_gnt;
   assign bus.dma_gnt_out      = dma_gnt;
   assign bus.owner_out        = owner;
   assign bus.protocol_err_out = err;

endmodule

// File: tb/tb_cpumc_arbiter.sv
// Bench for cpumc_arbiter: directed scenarios plus random traffic, all checked against
// an ownership-level reference model.
module tb_cpumc_arbiter;

   localparam int GUARD = 1;
   localparam int MAXW  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: who owns the bus (0 cpu, 1 hci, 2 dma, 3 none), guard cycles left,
   // consecutive stalled writes, sticky error.
   int m_owner;
   int m_guard;
   int m_wr;
   bit m_err;

   cpumc_arbiter_if bus();

   cpumc_arbiter #(.GUARD_CYCLES(GUARD), .MAX_WR_WAIT(MAXW)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_owner = 0;
      m_guard = 0;
      m_wr    = 0;
      m_err   = 1'b0;
   endfunction

   function automatic void model_release(input bit any);
      m_wr = 0;
      if (GUARD > 0) begin
         m_owner = 3;
         m_guard = GUARD;
      end else begin
         m_owner = any ? 3 : 0;
      end
   endfunction

   function automatic void model_step(input bit hreq, input bit dreq, input bit rnw);
      bit any = hreq | dreq;
      case (m_owner)
         0: if (any) begin
               m_owner = 3;
               m_guard = 0;
               m_wr    = 0;
            end
         1: if (!hreq) model_release(any);
         2: if (!dreq) model_release(any);
         default: begin
            if (m_guard > 0) begin
               m_guard--;
               if (m_guard == 0) m_owner = any ? 3 : 0;
            end else if (!any) begin
               m_owner = 0;
               m_wr    = 0;
            end else if (rnw) begin
               m_owner = hreq ? 1 : 2;
               m_wr    = 0;
            end else begin
               m_wr++;
               if (m_wr > MAXW) m_err = 1'b1;
            end
         end
      endcase
   endfunction

   task automatic compare();
      logic [15:0] ea;
      logic        en;
      logic [7:0]  ed;
      ea = bus.cpu_a_in;
      en = 1'b1;
      ed = bus.cpu_d_in;
      case (m_owner)
         0: en = bus.cpu_r_nw_in;
         1: begin ea = bus.hci_a_in; en = bus.hci_r_nw_in; ed = bus.hci_d_in; end
         2: begin ea = bus.dma_a_in; en = bus.dma_r_nw_in; ed = bus.dma_d_in; end
         default: ;
      endcase
      check("rdy",     32'(bus.cpu_rdy_out),      32'(m_owner == 0));
      check("hci_gnt", 32'(bus.hci_gnt_out),      32'(m_owner == 1));
      check("dma_gnt", 32'(bus.dma_gnt_out),      32'(m_owner == 2));
      check("owner",   32'(bus.owner_out),        32'(m_owner));
      check("err",     32'(bus.protocol_err_out), 32'(m_err));
      check("mc_a",    32'(bus.mc_a_out),         32'(ea));
      check("mc_r_nw", 32'(bus.mc_r_nw_out),      32'(en));
      check("mc_d",    32'(bus.mc_d_out),         32'(ed));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(bus.hci_req_in, bus.dma_req_in, bus.cpu_r_nw_in);
      @(negedge clk);
      compare();
   endtask

   task automatic rand_data();
      bus.cpu_a_in    = 16'($urandom);
      bus.cpu_d_in    = 8'($urandom);
      bus.hci_a_in    = 16'($urandom);
      bus.hci_d_in    = 8'($urandom);
      bus.hci_r_nw_in = 1'($urandom);
      bus.dma_a_in    = 16'($urandom);
      bus.dma_d_in    = 8'($urandom);
      bus.dma_r_nw_in = 1'($urandom);
   endtask

   task automatic set_idle();
      bus.hci_req_in  = 1'b0;
      bus.dma_req_in  = 1'b0;
      bus.cpu_r_nw_in = 1'b1;
      rand_data();
   endtask

   // Called at a negedge; returns at the following negedge with reset released.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      compare();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      set_idle();
      model_reset();
      @(negedge clk);
      do_reset();
      check("reset_rdy",   32'(bus.cpu_rdy_out), 32'd1);
      check("reset_owner", 32'(bus.owner_out),   32'd0);

      // DMA takeover on a CPU read cycle, then release through one guard cycle
      bus.dma_req_in = 1'b1;
      tick();
      check("dma_rdy_e1", 32'(bus.cpu_rdy_out), 32'd0);
      check("dma_gnt_e1", 32'(bus.dma_gnt_out), 32'd0);
      tick();
      check("dma_gnt_e2",   32'(bus.dma_gnt_out), 32'd1);
      check("dma_owner_e2", 32'(bus.owner_out),   32'd2);
      for (int i = 3; i <= 10; i++) begin
         rand_data();
         tick();
      end
      bus.dma_req_in = 1'b0;
      tick();
      check("dma_gnt_e11", 32'(bus.dma_gnt_out), 32'd0);
      check("dma_rdy_e11", 32'(bus.cpu_rdy_out), 32'd0);
      tick();
      check("dma_rdy_e12",   32'(bus.cpu_rdy_out), 32'd1);
      check("dma_owner_e12", 32'(bus.owner_out),   32'd0);

      // HCI request while the CPU keeps writing for three stall cycles
      @(negedge clk);
      do_reset();
      set_idle();
      bus.cpu_r_nw_in = 1'b0;
      bus.hci_req_in  = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("drain_gnt",   32'(bus.hci_gnt_out),      32'd0);
         check("drain_rnw",   32'(bus.mc_r_nw_out),      32'd1);
         check("drain_noerr", 32'(bus.protocol_err_out), 32'd0);
      end
      bus.cpu_r_nw_in = 1'b1;
      tick();
      check("drain_gnt_rd", 32'(bus.hci_gnt_out),      32'd1);
      check("drain_err_rd", 32'(bus.protocol_err_out), 32'd0);
      bus.hci_a_in    = 16'h2006;
      bus.hci_r_nw_in = 1'b0;
      bus.hci_d_in    = 8'h3F;
      #1;
      check("mux_a",    32'(bus.mc_a_out),    32'h2006);
      check("mux_r_nw", 32'(bus.mc_r_nw_out), 32'd0);
      check("mux_d",    32'(bus.mc_d_out),    32'h3F);
      tick();

      // Four stalled writes trip the sticky error but never force a grant
      do_reset();
      set_idle();
      bus.cpu_r_nw_in = 1'b0;
      bus.hci_req_in  = 1'b1;
      repeat (4) tick();
      check("wr3_err", 32'(bus.protocol_err_out), 32'd0);
      tick();
      check("wr4_err", 32'(bus.protocol_err_out), 32'd1);
      check("wr4_gnt", 32'(bus.hci_gnt_out),      32'd0);
      bus.cpu_r_nw_in = 1'b1;
      tick();
      check("wr4_gnt_rd", 32'(bus.hci_gnt_out),      32'd1);
      check("wr4_sticky", 32'(bus.protocol_err_out), 32'd1);

      // Simultaneous requests: HCI first, DMA after guard and stall, CPU never resumed
      do_reset();
      set_idle();
      bus.hci_req_in = 1'b1;
      bus.dma_req_in = 1'b1;
      tick();
      tick();
      check("sim_hci_gnt", 32'(bus.hci_gnt_out), 32'd1);
      check("sim_dma_gnt", 32'(bus.dma_gnt_out), 32'd0);
      repeat (3) tick();
      bus.hci_req_in = 1'b0;
      tick();
      check("sim_guard_owner", 32'(bus.owner_out),   32'd3);
      check("sim_guard_rdy",   32'(bus.cpu_rdy_out), 32'd0);
      tick();
      check("sim_stall_owner", 32'(bus.owner_out),   32'd3);
      check("sim_stall_rdy",   32'(bus.cpu_rdy_out), 32'd0);
      tick();
      check("sim_dma_gnt2", 32'(bus.dma_gnt_out), 32'd1);
      check("sim_dma_rdy",  32'(bus.cpu_rdy_out), 32'd0);

      // One-cycle DMA request during a CPU write is abandoned in STALL
      do_reset();
      set_idle();
      bus.cpu_r_nw_in = 1'b0;
      bus.dma_req_in  = 1'b1;
      tick();
      check("abort_rdy0", 32'(bus.cpu_rdy_out), 32'd0);
      bus.dma_req_in = 1'b0;
      tick();
      check("abort_rdy1", 32'(bus.cpu_rdy_out), 32'd1);
      check("abort_gnt",  32'(bus.dma_gnt_out), 32'd0);

      // Asynchronous reset in the middle of a DMA grant
      do_reset();
      set_idle();
      bus.dma_req_in = 1'b1;
      tick();
      tick();
      check("rstmid_pre_gnt", 32'(bus.dma_gnt_out), 32'd1);
      bus.cpu_a_in = 16'hBEEF;
      rst = 1'b1;
      #1;
      check("rstmid_rdy",   32'(bus.cpu_rdy_out), 32'd1);
      check("rstmid_gnt",   32'(bus.dma_gnt_out), 32'd0);
      check("rstmid_owner", 32'(bus.owner_out),   32'd0);
      check("rstmid_mc_a",  32'(bus.mc_a_out),    32'hBEEF);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      set_idle();

      // Random traffic with level requests and occasional resets
      repeat (3000) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         if ($urandom_range(0, 11) == 0) bus.hci_req_in = ~bus.hci_req_in;
         if ($urandom_range(0, 9) == 0)  bus.dma_req_in = ~bus.dma_req_in;
         bus.cpu_r_nw_in = ($urandom_range(0, 3) != 0);
         rand_data();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpumc_arbiter.md
Name: cpumc_arbiter

Overview:
- Sequencer for the CPU memory bus (cpumc_a / cpumc_r_nw / cpumc_din).
- Shares the bus between three requesters: rp2a03 (default owner), HCI debug access, and a DMA engine (sprite/OAM DMA).
- Stalls the CPU through its RDY input and hands the bus over only on a CPU read cycle, because RDY does not halt a 6502 write.
- Replaces the purely combinational hci_active mux with a request/grant handshake.

Parameters:
- GUARD_CYCLES, 1: idle read-only cycles inserted after a non-CPU owner releases, before the CPU regains the bus (0..15).
- MAX_WR_WAIT, 3: maximum consecutive CPU write cycles tolerated in STALL before protocol_err_out is set.

Ports:
- clk_in  in  1  system clock (100 MHz)
- rst_in  in  1  reset, asynchronous, active-high
- cpu_a_in  in  16  rp2a03 address
- cpu_r_nw_in  in  1  rp2a03 read/not-write
- cpu_d_in  in  8  rp2a03 write data
- cpu_rdy_out  out  1  rp2a03 RDY
- hci_req_in  in  1  HCI bus request (level)
- hci_gnt_out  out  1  HCI grant
- hci_a_in  in  16  HCI address
- hci_r_nw_in  in  1  HCI read/not-write
- hci_d_in  in  8  HCI write data
- dma_req_in  in  1  DMA bus request (level)
- dma_gnt_out  out  1  DMA grant
- dma_a_in  in  16  DMA address
- dma_r_nw_in  in  1  DMA read/not-write
- dma_d_in  in  8  DMA write data
- mc_a_out  out  16  cpumc_a
- mc_r_nw_out  out  1  cpumc_r_nw
- mc_d_out  out  8  cpumc_din
- owner_out  out  2  current owner: 0 CPU, 1 HCI, 2 DMA, 3 none (stall/guard)
- protocol_err_out  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-high.
- Reset values: state CPU; cpu_rdy_out=1; hci_gnt_out=0; dma_gnt_out=0; owner_out=0; protocol_err_out=0; guard and write-wait counters 0.
- Registered control: state, grants, rdy and owner are all registered.
- Bus mux: combinational from the registered state.
  - CPU: mc_* = cpu_*.
  - HCI: mc_* = hci_*.
  - DMA: mc_* = dma_*.
  - STALL/GUARD: mc_a_out = cpu_a_in, mc_r_nw_out forced to 1, mc_d_out = cpu_d_in.
- States: CPU, STALL, HCI, DMA, GUARD.
- CPU: if hci_req_in or dma_req_in is high, go to STALL next cycle.
  - cpu_rdy_out=0 from that edge.
  - The current CPU cycle completes on the bus unchanged.
- STALL: rdy=0, owner=3.
  - If cpu_r_nw_in=1, go to HCI if hci_req_in, else DMA if dma_req_in. The matching grant rises on the same edge (latency: request to grant = 2 cycles minimum).
  - If both requests have dropped, return to CPU with rdy=1; no grant is issued.
  - Each STALL cycle with cpu_r_nw_in=0 increments wr_wait. When wr_wait exceeds MAX_WR_WAIT, set protocol_err_out (sticky until reset). Keep waiting; never force a grant.
  - wr_wait clears on leaving STALL.
- Priority: HCI over DMA on simultaneous requests.
- No preemption:
  - HCI arriving while DMA owns waits until dma_req_in drops.
  - On release, go to STALL→HCI via GUARD; the CPU is not resumed in between.
- HCI/DMA ownership: grant held while the request stays high. When the request drops, clear the grant on the next edge and go to GUARD.
- GUARD: rdy=0, owner=3. Counts GUARD_CYCLES cycles, then:
  - goes to STALL if any request is pending (rdy stays 0),
  - otherwise goes to CPU with rdy=1.
  - GUARD_CYCLES=0 skips GUARD.
- Grant exclusivity: hci_gnt_out and dma_gnt_out are never both 1. A grant is never 1 while cpu_rdy_out=1.
- Reset mid-transfer: immediate return to reset values. A requester seeing its grant fall must abandon its transfer.

Decomposition:
- Package cpumc_pkg holds:
  - the owner encodings (OWNER_CPU=0, OWNER_HCI=1, OWNER_DMA=2, OWNER_NONE=3),
  - the state encoding,
  - the 16-bit address and 8-bit data width constants.
- No sub-module; the guard and write-wait counters are inline.

Test Plan:
- Reset: rst_in pulsed mid-DMA grant → same cycle cpu_rdy_out=1, dma_gnt_out=0, owner_out=0, mc_a_out=cpu_a_in.
- DMA on a read cycle: cpu_r_nw_in=1, dma_req_in rises at cycle 0 → rdy=0 at edge 1, dma_gnt_out=1 and owner_out=2 at edge 2. Drop req at cycle 10 → gnt=0 at edge 11, GUARD 1 cycle, rdy=1 at edge 12.
- Write drain: cpu_r_nw_in=0 for 3 cycles after hci_req_in rises → no grant during writes, mc_r_nw_out=1 in STALL, hci_gnt_out rises the edge after the first read, protocol_err_out stays 0. A 4th write sets protocol_err_out=1.
- Simultaneous: hci_req_in and dma_req_in rise together → HCI granted first. After HCI drops: GUARD, then STALL, then dma_gnt_out; rdy stays 0 throughout.
- Abort in STALL: dma_req_in high for 1 cycle during a CPU write → return to CPU, rdy=1, dma_gnt_out never asserted.
- Mux: HCI granted with hci_a_in=16'h2006, hci_r_nw_in=0, hci_d_in=8'h3F → mc_a_out=16'h2006, mc_r_nw_out=0, mc_d_out=8'h3F.
